// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI command controller: FSM states, header layout, write-FIFO entry.
// The entry struct is sized from SPI_W/SPI_A, so W/A overrides must be mirrored here.
package spi_cmd_pkg;
   localparam int SPI_W      = 16;
   localparam int SPI_A      = 8;
   localparam int HDR_WR_BIT = SPI_W - 1;

   typedef enum logic [1:0] {IDLE, HDR, DATA, SKIP} state_t;

   typedef struct packed {
      logic [SPI_A-1:0] addr;
      logic [SPI_W-1:0] data;
   } wr_entry_t;
endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous FIFO for queued register writes; head is visible combinationally.
module spi_cmd_fifo #(
   parameter int EW    = 24,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [EW-1:0] din,
   output logic [EW-1:0] head,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [AW:0]   wp, rp;

   // Extra pointer bit distinguishes full from empty when indices match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wp[AW-1:0]] <= din;
            wp <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
      end
   end

   assign head  = mem[rp[AW-1:0]];
   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/spi_cmd_ctrl.sv
// Frame decoder: header word then auto-incrementing writes into a backpressured FIFO.
// Define SPI_CMD_STATS_EN to add saturating frame_count/drop_count outputs.
module spi_cmd_ctrl
   import spi_cmd_pkg::*;
#(
   parameter int W     = SPI_W,
   parameter int A     = SPI_A,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] rx_word,
   input  logic         rx_valid,
   input  logic         rx_start,
   input  logic         rx_end,
   output logic [A-1:0] wr_addr,
   output logic [W-1:0] wr_data,
   output logic         wr_valid,
   input  logic         wr_ready,
   input  logic         clr_err,
   output logic         busy,
   output logic         frame_done,
   output logic         frame_err,
   output logic         overflow
`ifdef SPI_CMD_STATS_EN
   ,
   output logic [15:0]  frame_count,
   output logic [15:0]  drop_count
`endif
);
   state_t       state, state_n;
   logic [A-1:0] addr_cnt, addr_n;
   logic         push_req, push_ok, pop, drop, full, empty, done_n, err_n;
   wr_entry_t    din, head;

   assign pop     = !empty && wr_ready;
   assign push_ok = push_req && (!full || pop);
   assign drop    = push_req && !push_ok;
   assign din     = '{addr: addr_cnt, data: rx_word};

   spi_cmd_fifo #(.EW($bits(wr_entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   assign wr_valid = !empty;
   assign wr_addr  = head.addr;
   assign wr_data  = head.data;
   assign busy     = (state != IDLE) || !empty;

   // Word first, then rx_end, then rx_start, so coincident strobes resolve in that order.
   always_comb begin
      state_n  = state;
      addr_n   = addr_cnt;
      push_req = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b0;
      if (state != IDLE && rx_valid) begin
         case (state)
            HDR: begin
               if (rx_word[HDR_WR_BIT]) begin
                  state_n = DATA;
                  addr_n  = rx_word[A-1:0];
               end else begin
                  state_n = SKIP;
               end
            end
            DATA: begin
               push_req = 1'b1;
               addr_n   = addr_cnt + 1'b1;
            end
            default: ;
         endcase
      end
      if (state != IDLE) begin
         if (rx_end) begin
            done_n  = 1'b1;
            err_n   = (state_n == HDR);
            state_n = IDLE;
         end else if (rx_start) begin
            err_n = 1'b1;
         end
      end
      if (rx_start) state_n = HDR;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr_cnt   <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_n;
         addr_cnt   <= addr_n;
         frame_done <= done_n;
         frame_err  <= err_n;
         overflow   <= drop | (overflow & ~clr_err);
      end
   end

`ifdef SPI_CMD_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_count <= '0;
         drop_count  <= '0;
      end else begin
         if (clr_err)                                frame_count <= {15'd0, done_n};
         else if (done_n && frame_count != 16'hFFFF) frame_count <= frame_count + 1'b1;
         if (clr_err)                                drop_count  <= {15'd0, drop};
         else if (drop && drop_count != 16'hFFFF)    drop_count  <= drop_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: frame-level reference model plus negedge monitor.
`timescale 1ns/1ps
module tb_spi_cmd_ctrl;
   localparam int W = 16, A = 8, DEPTH = 4;

   logic         clk = 1'b0, reset = 1'b1;
   logic [W-1:0] rx_word = '0;
   logic         rx_valid = 1'b0, rx_start = 1'b0, rx_end = 1'b0;
   logic         wr_ready = 1'b0, clr_err = 1'b0;
   logic [A-1:0] wr_addr;
   logic [W-1:0] wr_data;
   logic         wr_valid, busy, frame_done, frame_err, overflow;
`ifdef SPI_CMD_STATS_EN
   logic [15:0]  frame_count, drop_count;
`endif

   int errors = 0, checks = 0, n_writes = 0, n_ferr = 0;
   bit rnd_ready = 0;

   always #5 clk = ~clk;

   spi_cmd_ctrl #(.W(W), .A(A), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .rx_word(rx_word), .rx_valid(rx_valid),
      .rx_start(rx_start), .rx_end(rx_end), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .clr_err(clr_err), .busy(busy),
      .frame_done(frame_done), .frame_err(frame_err), .overflow(overflow)
`ifdef SPI_CMD_STATS_EN
      , .frame_count(frame_count), .drop_count(drop_count)
`endif
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame mode, write address, occupancy, expected write list.
   typedef enum {M_IDLE, M_HDR, M_WR, M_SKIP} mode_t;
   mode_t          mode = M_IDLE;
   logic [A-1:0]   m_addr = '0;
   int             m_cnt = 0, e_fc = 0, e_dc = 0;
   bit             e_done = 0, e_err = 0, e_ovf = 0, m_pop, m_drop;
   logic [A+W-1:0] exp_q[$];
   logic [A+W-1:0] got_q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mode = M_IDLE; m_addr = '0; m_cnt = 0;
         e_done = 0; e_err = 0; e_ovf = 0; e_fc = 0; e_dc = 0;
         exp_q.delete();
      end else begin
         m_pop  = (m_cnt > 0) && wr_ready;
         m_drop = 0;
         e_done = 0;
         e_err  = 0;
         if (clr_err) begin e_ovf = 0; e_fc = 0; e_dc = 0; end
         if (rx_valid && mode == M_HDR) begin
            mode = rx_word[W-1] ? M_WR : M_SKIP;
            if (rx_word[W-1]) m_addr = rx_word[A-1:0];
         end else if (rx_valid && mode == M_WR) begin
            if (m_cnt < DEPTH || m_pop) begin
               exp_q.push_back({m_addr, rx_word});
               m_cnt++;
            end else begin
               m_drop = 1;
               e_ovf  = 1;
            end
            m_addr = m_addr + 1'b1;
         end
         if (rx_end && mode != M_IDLE) begin
            e_done = 1;
            e_err  = (mode == M_HDR);
            mode   = M_IDLE;
         end else if (rx_start && mode != M_IDLE) begin
            e_err = 1;
         end
         if (rx_start) mode = M_HDR;
         if (m_pop) m_cnt--;
         if (e_done && e_fc < 65535) e_fc++;
         if (m_drop && e_dc < 65535) e_dc++;
      end
   end

   always @(negedge clk) begin
      chk("wr_valid", wr_valid, m_cnt != 0);
      chk("busy", busy, (mode != M_IDLE) || (m_cnt != 0));
      chk("frame_done", frame_done, e_done);
      chk("frame_err", frame_err, e_err);
      chk("overflow", overflow, e_ovf);
`ifdef SPI_CMD_STATS_EN
      chk("frame_count", frame_count, e_fc);
      chk("drop_count", drop_count, e_dc);
`endif
      if (frame_err) n_ferr++;
      if (wr_valid && wr_ready && exp_q.size() != 0) begin
         chk("wr_addr", wr_addr, exp_q[0][A+W-1:W]);
         chk("wr_data", wr_data, exp_q[0][W-1:0]);
         got_q.push_back({wr_addr, wr_data});
         void'(exp_q.pop_front());
         n_writes++;
      end
   end

   task automatic step(bit v = 0, bit s = 0, bit e = 0, logic [W-1:0] w = '0);
      rx_valid = v; rx_start = s; rx_end = e; rx_word = w;
      if (rnd_ready) wr_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      rx_valid = 0; rx_start = 0; rx_end = 0; clr_err = 0;
   endtask

   task automatic word(logic [W-1:0] w);
      step(1, 0, 0, w);
   endtask

   task automatic drain();
      int i = 0;
      while (busy && i < 100) begin step(); i++; end
      chk("drain_timeout", busy, 0);
   endtask

   int n0, f0;
   logic [W-1:0] hdr;

   initial begin
      reset = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_valid", wr_valid, 0);
      reset = 0;
      wr_ready = 1;

      // T1: basic write frame
      got_q.delete(); n0 = n_writes;
      step(0, 1); word(16'h8010); word(16'h1111); word(16'h2222); step(0, 0, 1);
      drain();
      chk("t1_writes", n_writes - n0, 2);
      if (got_q.size() == 2) begin
         chk("t1_w0", got_q[0], {8'h10, 16'h1111});
         chk("t1_w1", got_q[1], {8'h11, 16'h2222});
      end

      // T2: read header -> words skipped
      n0 = n_writes; f0 = n_ferr;
      step(0, 1); word(16'h0010); word(16'hAAAA); word(16'hBBBB); step(0, 0, 1);
      drain();
      chk("t2_writes", n_writes - n0, 0);
      chk("t2_ferr", n_ferr - f0, 0);

      // T3: overflow with sink stalled
      got_q.delete(); n0 = n_writes;
      wr_ready = 0;
      step(0, 1); word(16'h8000);
      for (int i = 0; i < 6; i++) word(16'h0100 + 16'(i));
      step(0, 0, 1);
      chk("t3_ovf_set", overflow, 1);
`ifdef SPI_CMD_STATS_EN
      chk("t3_drop_count", drop_count, 2);
`endif
      wr_ready = 1;
      drain();
      chk("t3_writes", n_writes - n0, 4);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         chk("t3_addr", got_q[i][A+W-1:W], i);
      clr_err = 1; step();
      chk("t3_ovf_clr", overflow, 0);

      // T4: address wrap
      got_q.delete();
      step(0, 1); word(16'h80FF); word(16'h0A0A); word(16'h0B0B); step(0, 0, 1);
      drain();
      if (got_q.size() == 2) begin
         chk("t4_a0", got_q[0][A+W-1:W], 8'hFF);
         chk("t4_a1", got_q[1][A+W-1:W], 8'h00);
      end else chk("t4_count", got_q.size(), 2);

      // T5: restart mid-frame
      got_q.delete(); f0 = n_ferr;
      step(0, 1); word(16'h8020); word(16'h1234); step(0, 1); word(16'h8040); word(16'h5555);
      step(0, 0, 1);
      drain();
      chk("t5_ferr", n_ferr - f0, 1);
      if (got_q.size() == 2) begin
         chk("t5_w0", got_q[0], {8'h20, 16'h1234});
         chk("t5_w1", got_q[1], {8'h40, 16'h5555});
      end else chk("t5_count", got_q.size(), 2);

      // T6: reset mid-frame with queued entries
      wr_ready = 0;
      step(0, 1); word(16'h8000); word(16'h0001); word(16'h0002); word(16'h0003);
      chk("t6_queued", wr_valid, 1);
      reset = 1; #1;
      chk("t6_wr_valid", wr_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ovf", overflow, 0);
      @(posedge clk); #1;
      reset = 0;
      word(16'h8123); word(16'h4444); step(); step();
      chk("t6_no_write", wr_valid, 0);
      wr_ready = 1;

      // Randomized frames with random backpressure and occasional restarts
      rnd_ready = 1;
      for (int f = 0; f < 40; f++) begin
         hdr = 16'($urandom);
         hdr[W-1] = ($urandom_range(0, 3) != 0);
         step(0, 1);
         if ($urandom_range(0, 9) != 0) word(hdr);
         for (int k = $urandom_range(0, 7); k > 0; k--) begin
            word(16'($urandom));
            if ($urandom_range(0, 3) == 0) step();
         end
         if ($urandom_range(0, 5) == 0) clr_err = 1;
         if ($urandom_range(0, 7) != 0) step(0, 0, 1);
         repeat ($urandom_range(0, 3)) step();
      end
      rnd_ready = 0;
      wr_ready = 1;
      step(0, 0, 1);
      drain();
      chk("final_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Frame-level controller behind the SPI word receiver. It consumes received words plus chip-select start and end strobes, and decodes each frame as one header word followed by data words. Data words become auto-incrementing register-bus writes, queued in a small FIFO with valid/ready backpressure toward the register file. It flags protocol errors and overflow so firmware can recover.

Parameters:
W, 16, SPI word width (matches receiver width)
A, 8, register address width; must satisfy A <= W-1
DEPTH, 4, write-FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_word  in  W  received word, valid while rx_valid is high
rx_valid  in  1  one-cycle pulse: rx_word complete
rx_start  in  1  one-cycle pulse: chip select asserted (frame start)
rx_end  in  1  one-cycle pulse: chip select released (frame end)
wr_addr  out  A  write address (FIFO head)
wr_data  out  W  write data (FIFO head)
wr_valid  out  1  head entry valid
wr_ready  in  1  sink accepts head this cycle
clr_err  in  1  clears sticky error flags
busy  out  1  state != IDLE or FIFO not empty
frame_done  out  1  one-cycle pulse, registered, one cycle after rx_end
frame_err  out  1  one-cycle pulse: rx_start seen while not IDLE, or rx_end in HDR
overflow  out  1  sticky: a data word was dropped because the FIFO was full

Behaviour:
- Reset (async): state=IDLE; FIFO empty; addr counter=0; all outputs 0.
- Header word: bit W-1 = 1 means write frame; bits A-1:0 = start address; other bits are ignored.
- FSM states: IDLE, HDR, DATA, SKIP.
  - IDLE: rx_start -> HDR. rx_valid is ignored.
  - HDR: rx_valid with header bit set -> DATA, addr counter loads header[A-1:0]. rx_valid with bit clear -> SKIP.
  - DATA: each rx_valid pushes {addr counter, rx_word}, then addr counter increments. Address wraps modulo 2^A (0xFF -> 0x00).
  - SKIP: all words are discarded.
  - Any non-IDLE state: rx_end -> IDLE and frame_done pulses. If the state was HDR, frame_err also pulses.
  - Any non-IDLE state: rx_start -> HDR, addr counter unchanged, frame_err pulses.
  - rx_start and rx_end in the same cycle: rx_end is processed first, then rx_start -> HDR.
  - rx_valid and rx_end in the same cycle: the word is processed first, then the transition to IDLE.
- FIFO:
  - Push happens on the clk edge after rx_valid. wr_valid is high the following cycle (1-cycle latency, rx_valid to wr_valid).
  - wr_valid = not empty. wr_addr and wr_data always show the head entry and are held stable until popped.
  - Pop when wr_valid && wr_ready.
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow sets, and the addr counter still increments, so the following words keep their addresses.
- FIFO entries already queued drain after rx_end. busy stays high until the FIFO is empty.
- Sticky flags: clr_err clears overflow. If set and clear coincide, set wins.
- Reset asserted mid-frame: queued writes are discarded and the block returns to IDLE. The next word is accepted as a header only after a fresh rx_start.

Optional Feature:
SPI_CMD_STATS_EN
- Defined: adds outputs frame_count[15:0] (increments on each frame_done) and drop_count[15:0] (increments on each dropped word).
  - Both counters saturate at 0xFFFF.
  - Both reset to 0 and are cleared by clr_err.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package spi_cmd_pkg holds:
  - state enum (IDLE, HDR, DATA, SKIP)
  - localparam for the header write-bit position (W-1)
  - the FIFO entry struct {addr, data}
- One sub-module: spi_cmd_fifo, a synchronous FIFO (DEPTH, entry width A+W) with push, pop, full, empty, head outputs, async reset.
- The FSM, addr counter and flags live in spi_cmd_ctrl.

Test Plan (W=16, A=8, DEPTH=4):
1. rx_start, words 0x8010, 0x1111, 0x2222, rx_end, wr_ready=1 -> writes (0x10,0x1111), (0x11,0x2222); frame_done pulses once; busy then falls to 0.
2. Header 0x0010 followed by 0xAAAA, 0xBBBB -> no wr_valid, SKIP until rx_end, frame_done pulses, frame_err=0.
3. wr_ready=0, header 0x8000 plus 6 data words -> 4 entries queued, overflow=1. Then wr_ready=1 -> addresses 0x00-0x03 drain. clr_err -> overflow=0 (drop_count=2 with SPI_CMD_STATS_EN).
4. Header 0x80FF plus 2 data words -> wr_addr 0xFF then 0x00.
5. Header 0x8020, one data word, then rx_start again, then 0x8040, 0x5555 -> frame_err pulses; writes (0x20,...) and (0x40,0x5555).
6. Reset asserted with 3 entries queued during DATA -> wr_valid=0, busy=0, overflow=0 immediately. A data word before the next rx_start produces no write.
